// File: rtl/pulp_cluster_package.sv
// Cluster-wide constants shared by peripheral interconnect blocks.
package pulp_cluster_package;

  localparam int unsigned PER_NB_OUPS         = 8;
  localparam int unsigned PER_MAX_OUTSTANDING = 4;
  localparam int unsigned PER_ADDR_W          = 32;

endpackage : pulp_cluster_package

// File: rtl/per_demux_ordered.sv
// Peripheral demultiplexer that keeps responses in grant order by only
// allowing outstanding requests towards a single target at a time.
module per_demux_ordered
  import pulp_cluster_package::*;
#(
  parameter int unsigned NB_OUPS         = PER_NB_OUPS,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = PER_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [$clog2(NB_OUPS)-1:0]         sel_i,
  input  logic                               m_req_i,
  input  logic [PER_ADDR_W-1:0]              m_add_i,
  input  logic                               m_wen_i,
  input  logic [DATA_W-1:0]                  m_wdata_i,
  input  logic [DATA_W/8-1:0]                m_be_i,
  output logic                               m_gnt_o,
  output logic                               m_r_valid_o,
  output logic [DATA_W-1:0]                  m_r_rdata_o,
  output logic                               m_r_opc_o,
  output logic [NB_OUPS-1:0]                 s_req_o,
  output logic [PER_ADDR_W-1:0]              s_add_o,
  output logic                               s_wen_o,
  output logic [DATA_W-1:0]                  s_wdata_o,
  output logic [DATA_W/8-1:0]                s_be_o,
  input  logic [NB_OUPS-1:0]                 s_gnt_i,
  input  logic [NB_OUPS-1:0]                 s_r_valid_i,
  input  logic [NB_OUPS-1:0][DATA_W-1:0]     s_r_rdata_i,
  input  logic [NB_OUPS-1:0]                 s_r_opc_i,
  output logic                               stray_rsp_o
);

  localparam int unsigned SEL_W = $clog2(NB_OUPS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [SEL_W-1:0]   r_cur_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cnt_zero;
  logic               w_full;
  logic               w_allow;
  logic               w_fire;
  logic [NB_OUPS-1:0] w_exp_mask;

  // Request-side and response-side steering; full count never bypasses.
  always_comb begin
    w_cnt_zero  = (r_cnt == '0);
    w_full      = (r_cnt >= CNT_W'(MAX_OUTSTANDING));
    w_allow     = (w_cnt_zero || (sel_i == r_cur_idx)) && !w_full;
    w_fire      = m_req_i && w_allow;
    s_req_o     = '0;
    if (w_fire) s_req_o[sel_i] = 1'b1;
    m_gnt_o     = w_fire && s_gnt_i[sel_i];
    w_exp_mask  = '0;
    if (!w_cnt_zero) w_exp_mask[r_cur_idx] = 1'b1;
    m_r_valid_o = |(s_r_valid_i & w_exp_mask);
    m_r_rdata_o = m_r_valid_o ? s_r_rdata_i[r_cur_idx] : '0;
    m_r_opc_o   = m_r_valid_o ? s_r_opc_i[r_cur_idx] : 1'b0;
    stray_rsp_o = |(s_r_valid_i & ~w_exp_mask);
  end

  assign s_add_o   = m_add_i;
  assign s_wen_o   = m_wen_i;
  assign s_wdata_o = m_wdata_i;
  assign s_be_o    = m_be_i;

  // Outstanding tracker: simultaneous grant and response cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_idx <= '0;
      r_cnt     <= '0;
    end else begin
      if (m_gnt_o) r_cur_idx <= sel_i;
      case ({m_gnt_o, m_r_valid_o})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule : per_demux_ordered

// File: doc/per_demux_ordered.md
PER_DEMUX_ORDERED -- requirements
Module: per_demux_ordered

Interface
REQ-001 SHALL have parameter NB_OUPS, default 8: number of peripheral target ports (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: max unanswered granted requests (>=1).
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sel_i  input  $clog2(NB_OUPS)  target index from the cluster peripheral address decoder, valid with m_req_i.
REQ-007 SHALL have master ports m_req_i 1, m_add_i 32, m_wen_i 1 (1=read), m_wdata_i DATA_W, m_be_i DATA_W/8 as inputs; m_gnt_o 1 as output.
REQ-008 SHALL have master response outputs m_r_valid_o 1, m_r_rdata_o DATA_W, m_r_opc_o 1 (1=error).
REQ-009 SHALL have target outputs s_req_o NB_OUPS; s_add_o 32, s_wen_o 1, s_wdata_o DATA_W, s_be_o DATA_W/8, all broadcast.
REQ-010 SHALL have target inputs s_gnt_i NB_OUPS; s_r_valid_i NB_OUPS; s_r_rdata_i NB_OUPS x DATA_W; s_r_opc_i NB_OUPS.
REQ-011 SHALL have output stray_rsp_o 1: single-cycle pulse on an unexpected response.

Function
REQ-012 SHALL hold registers cur_idx (last granted target) and cnt (0..MAX_OUTSTANDING, outstanding count).
REQ-013 SHALL compute allow = (cnt==0 || sel_i==cur_idx) && cnt<MAX_OUTSTANDING.
REQ-014 SHALL drive s_req_o[sel_i] = m_req_i && allow; all other s_req_o bits 0; s_req_o all 0 when allow=0.
REQ-015 SHALL drive m_gnt_o = m_req_i && allow && s_gnt_i[sel_i], combinationally (zero-cycle grant path).
REQ-016 SHALL pass m_add_i, m_wen_i, m_wdata_i, m_be_i to s_* unregistered.
REQ-017 SHALL on grant (m_req_i && m_gnt_o) load cur_idx<=sel_i and increment cnt.
REQ-018 SHALL drive m_r_valid_o = (cnt!=0) && s_r_valid_i[cur_idx]; m_r_rdata_o/m_r_opc_o = s_r_rdata_i/s_r_opc_i[cur_idx]; rdata/opc 0 when m_r_valid_o=0.
REQ-019 SHALL decrement cnt on m_r_valid_o; grant and response in the same cycle leave cnt unchanged.
REQ-020 SHALL not bypass full: cnt==MAX_OUTSTANDING blocks requests even if a response arrives that cycle.
REQ-021 SHALL pulse stray_rsp_o for any s_r_valid_i[k] with cnt==0 or k!=cur_idx; such responses are dropped.
REQ-022 SHALL keep m_r_valid_o order identical to grant order (guaranteed by REQ-013 single-target rule).
REQ-023 SHALL tolerate m_req_i deassertion or sel_i change before grant without state change.

Reset
REQ-024 SHALL on rst_ni=0 asynchronously set cnt=0, cur_idx=0; outputs then m_gnt_o=0 (unless combinational path with cnt=0 and s_gnt_i), m_r_valid_o=0, stray_rsp_o=0, s_req_o=0 when m_req_i=0.
REQ-025 SHALL discard outstanding transactions on reset mid-operation; later responses flag stray_rsp_o.

Structure
REQ-026 SHALL take NB_OUPS default and MAX_OUTSTANDING default as constants from pulp_cluster_package.
REQ-027 SHALL be a single module, no sub-modules; cnt width $clog2(MAX_OUTSTANDING+1).

Verification
REQ-028 Read sel_i=3, s_gnt_i[3]=1 -> s_req_o=8'h08, m_gnt_o same cycle; s_r_valid_i[3] next cycle with 32'hCAFE0003 -> m_r_rdata_o=32'hCAFE0003, cnt 1->0.
REQ-029 Target 2 answered late, new request to sel_i=5 with cnt=1 -> s_req_o=0, m_gnt_o=0 until response on port 2, then grant to port 5.
REQ-030 Four back-to-back grants to target 1, no responses -> fifth request blocked; one response -> fifth still blocked that cycle, granted the next.
REQ-031 Grant and response to target 6 in same cycle with cnt=2 -> cnt stays 2.
REQ-032 s_r_valid_i[4]=1 with cnt=0 -> stray_rsp_o=1 one cycle, m_r_valid_o=0.
REQ-033 rst_ni low with cnt=3 -> cnt=0 immediately (async); following response -> stray_rsp_o=1.
